// File: rtl/cpu19_pkg.sv
// Shared definitions for the cpu19 register-file write path.
//   DATA_W     : register data width
//   REG_ADDR_W : register index width
//   NUM_REGS   : number of architectural registers (x0 hardwired to zero)
//   wb_req_t   : one pending register write (destination + data)
//   reg_bit()  : one-hot register mask for an index, x0 always masked off
package cpu19_pkg;

    localparam int unsigned DATA_W     = 19;
    localparam int unsigned REG_ADDR_W = 4;
    localparam int unsigned NUM_REGS   = 1 << REG_ADDR_W;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } wb_req_t;

    function automatic logic [NUM_REGS-1:0] reg_bit(input logic [REG_ADDR_W-1:0] rd);
        logic [NUM_REGS-1:0] mask;
        mask     = '0;
        mask[rd] = (rd != '0);
        return mask;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding long-latency results that lost write-port arbitration.
// Pointers carry one extra wrap bit so full and empty are told apart without a counter.
//   clk, reset_n : clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata  : enqueue wdata (ignored when full)
//   pop          : dequeue the head entry (ignored when empty)
//   head         : current head entry, valid while !empty
//   full, empty  : occupancy flags, derived from registered pointers only
module wb_fifo #(
    parameter int unsigned WIDTH = 23,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]   wr_q, rd_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[PTR_W] != rd_q[PTR_W]) &&
                     (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_q[PTR_W-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
        end
    end

    // Storage needs no reset: entries are only read between push and pop.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[PTR_W-1:0]] <= wdata;
    end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-side controller for the 16 x 19-bit register file (single write port, x0 = 0).
// Merges ALU results (highest priority, no backpressure) and long-latency LSU results
// onto the registered write port; losing LSU results wait in wb_fifo in arrival order.
// Tracks in-flight long destinations in busy_mask and flags write-after-write hazards.
//   clk, reset_n                    : clock, asynchronous active-low reset
//   alu_valid/alu_rd/alu_data       : single-cycle result
//   lsu_valid/lsu_ready/lsu_rd/...  : long-latency result handshake
//   iss_valid/iss_rd                : long op issued, marks iss_rd busy
//   busy_mask                       : registers with a long result still pending
//   wb_regwrite/wb_rd/wb_data       : registered register-file write port
//   err_waw                         : sticky write-after-write violation
// Data/address widths must match cpu19_pkg, whose wb_req_t carries queued results.
module regfile_wb_ctrl #(
    parameter int unsigned DATA_W     = 19,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    alu_valid,
    input  logic [ADDR_W-1:0]       alu_rd,
    input  logic [DATA_W-1:0]       alu_data,
    input  logic                    lsu_valid,
    output logic                    lsu_ready,
    input  logic [ADDR_W-1:0]       lsu_rd,
    input  logic [DATA_W-1:0]       lsu_data,
    input  logic                    iss_valid,
    input  logic [ADDR_W-1:0]       iss_rd,
    output logic [(2**ADDR_W)-1:0]  busy_mask,
    output logic                    wb_regwrite,
    output logic [ADDR_W-1:0]       wb_rd,
    output logic [DATA_W-1:0]       wb_data,
    output logic                    err_waw
);

    import cpu19_pkg::*;

    localparam int unsigned NREGS  = 2**ADDR_W;
    localparam int unsigned REQ_W  = $bits(wb_req_t);

    wb_req_t            alu_req, lsu_req, head_req, sel_req;
    logic [REQ_W-1:0]   head_bits;
    logic               fifo_full, fifo_empty;
    logic               lsu_acc, push, pop;
    logic               sel_valid, sel_long;

    logic               wb_regwrite_q, wb_long_q;
    logic [ADDR_W-1:0]  wb_rd_q;
    logic [DATA_W-1:0]  wb_data_q;
    logic [NREGS-1:0]   busy_q, busy_d;
    logic               err_q, err_d;

    assign alu_req.rd   = alu_rd;
    assign alu_req.data = alu_data;
    assign lsu_req.rd   = lsu_rd;
    assign lsu_req.data = lsu_data;
    assign head_req     = wb_req_t'(head_bits);

    // Depends on FIFO state only, so no path from lsu_valid.
    assign lsu_ready = !fifo_full;
    assign lsu_acc   = lsu_valid && !fifo_full;

    wb_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .wdata   (REQ_W'(lsu_req)),
        .pop     (pop),
        .head    (head_bits),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Source priority: ALU, then FIFO head, then a same-cycle LSU bypass. The FIFO head
    // beats a fresh LSU result so long results never overtake each other.
    always_comb begin
        sel_valid = 1'b0;
        sel_long  = 1'b0;
        sel_req   = alu_req;
        pop       = 1'b0;
        if (alu_valid) begin
            sel_valid = 1'b1;
        end else if (!fifo_empty) begin
            sel_valid = 1'b1;
            sel_long  = 1'b1;
            sel_req   = head_req;
            pop       = 1'b1;
        end else if (lsu_acc) begin
            sel_valid = 1'b1;
            sel_long  = 1'b1;
            sel_req   = lsu_req;
        end
        push = lsu_acc && (alu_valid || !fifo_empty);
    end

    // rd=0 results are consumed but never reach the register file.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_regwrite_q <= 1'b0;
            wb_long_q     <= 1'b0;
            wb_rd_q       <= '0;
            wb_data_q     <= '0;
        end else begin
            wb_regwrite_q <= sel_valid && (sel_req.rd != '0);
            wb_long_q     <= sel_long;
            if (sel_valid && (sel_req.rd != '0)) begin
                wb_rd_q   <= sel_req.rd;
                wb_data_q <= sel_req.data;
            end
        end
    end

    // A long result clears its bit at the edge that commits it to the register file;
    // a same-edge issue to that register re-sets it.
    always_comb begin
        busy_d = busy_q;
        if (wb_regwrite_q && wb_long_q) busy_d = busy_d & ~reg_bit(wb_rd_q);
        if (iss_valid)                  busy_d = busy_d | reg_bit(iss_rd);
        busy_d[0] = 1'b0;

        err_d = err_q;
        if (iss_valid && busy_q[iss_rd])                         err_d = 1'b1;
        if (alu_valid && (alu_rd != '0) && busy_q[alu_rd])       err_d = 1'b1;
        if (lsu_acc && !busy_q[lsu_rd])                          err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign busy_mask   = busy_q;
    assign wb_regwrite = wb_regwrite_q;
    assign wb_rd       = wb_rd_q;
    assign wb_data     = wb_data_q;
    assign err_waw     = err_q;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference model of the write path.
module tb_regfile_wb_ctrl;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        alu_valid = 1'b0;
    logic [3:0]  alu_rd = '0;
    logic [18:0] alu_data = '0;
    logic        lsu_valid = 1'b0;
    logic        lsu_ready;
    logic [3:0]  lsu_rd = '0;
    logic [18:0] lsu_data = '0;
    logic        iss_valid = 1'b0;
    logic [3:0]  iss_rd = '0;
    logic [15:0] busy_mask;
    logic        wb_regwrite;
    logic [3:0]  wb_rd;
    logic [18:0] wb_data;
    logic        err_waw;

    int n_checks = 0;
    int n_errors = 0;

    regfile_wb_ctrl #(
        .DATA_W     (19),
        .ADDR_W     (4),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .lsu_valid   (lsu_valid),
        .lsu_ready   (lsu_ready),
        .lsu_rd      (lsu_rd),
        .lsu_data    (lsu_data),
        .iss_valid   (iss_valid),
        .iss_rd      (iss_rd),
        .busy_mask   (busy_mask),
        .wb_regwrite (wb_regwrite),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .err_waw     (err_waw)
    );

    always #5 clk = ~clk;

    // Reference model: pending long results as a bounded queue, busy set as a bit array.
    typedef struct {
        logic [3:0]  rd;
        logic [18:0] data;
    } ent_t;

    ent_t        q[$];
    logic [15:0] m_busy;
    bit          m_err, m_we, m_long;
    logic [3:0]  m_rd;
    logic [18:0] m_data;

    task automatic model_reset();
        q.delete();
        m_busy = '0;
        m_err  = 0;
        m_we   = 0;
        m_long = 0;
        m_rd   = '0;
        m_data = '0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        bit          acc, have, long_src;
        ent_t        e;
        logic [15:0] nb;
        acc = lsu_valid && (q.size() < DEPTH);
        if (iss_valid && m_busy[iss_rd])                 m_err = 1;
        if (alu_valid && alu_rd != 0 && m_busy[alu_rd])  m_err = 1;
        if (acc && !m_busy[lsu_rd])                      m_err = 1;
        have = 0;
        long_src = 0;
        e.rd = alu_rd;
        e.data = alu_data;
        if (alu_valid) begin
            have = 1;
            if (acc) q.push_back('{lsu_rd, lsu_data});
        end else if (q.size() > 0) begin
            e = q.pop_front();
            have = 1;
            long_src = 1;
            if (acc) q.push_back('{lsu_rd, lsu_data});
        end else if (acc) begin
            e.rd = lsu_rd;
            e.data = lsu_data;
            have = 1;
            long_src = 1;
        end
        nb = m_busy;
        if (m_we && m_long) nb[m_rd] = 1'b0;
        if (iss_valid && iss_rd != 0) nb[iss_rd] = 1'b1;
        m_busy = nb;
        m_we   = have && (e.rd != 0);
        m_long = long_src;
        if (m_we) begin
            m_rd   = e.rd;
            m_data = e.data;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".wb_regwrite"}, 32'(wb_regwrite), 32'(m_we));
        if (m_we) begin
            chk({tag, ".wb_rd"},   32'(wb_rd),   32'(m_rd));
            chk({tag, ".wb_data"}, 32'(wb_data), 32'(m_data));
        end
        chk({tag, ".busy_mask"}, 32'(busy_mask), 32'(m_busy));
        chk({tag, ".err_waw"},   32'(err_waw),   32'(m_err));
        chk({tag, ".lsu_ready"}, 32'(lsu_ready), 32'(q.size() < DEPTH));
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    task automatic idle();
        alu_valid = 0;
        lsu_valid = 0;
        iss_valid = 0;
    endtask

    task automatic pulse_reset();
        reset_n = 0;
        #2;
        reset_n = 1;
        model_reset();
    endtask

    initial begin
        model_reset();
        #12;
        chk("reset.wb_regwrite", 32'(wb_regwrite), 32'd0);
        chk("reset.wb_rd",       32'(wb_rd),       32'd0);
        chk("reset.wb_data",     32'(wb_data),     32'd0);
        chk("reset.busy_mask",   32'(busy_mask),   32'd0);
        chk("reset.err_waw",     32'(err_waw),     32'd0);
        chk("reset.lsu_ready",   32'(lsu_ready),   32'd1);
        reset_n = 1;

        // ALU write appears one cycle after selection.
        @(posedge clk);
        #1;
        alu_valid = 1; alu_rd = 4'd3; alu_data = 19'h12345;
        tick("alu");
        chk("alu.we",   32'(wb_regwrite), 32'd1);
        chk("alu.rd",   32'(wb_rd),       32'd3);
        chk("alu.data", 32'(wb_data),     32'h12345);
        chk("alu.busy", 32'(busy_mask),   32'd0);
        idle();

        // Issue rd=5, LSU bypass, busy bit lifetime.
        iss_valid = 1; iss_rd = 4'd5;
        tick("iss5");
        chk("iss5.busy", 32'(busy_mask), 32'h0020);
        idle();
        lsu_valid = 1; lsu_rd = 4'd5; lsu_data = 19'h7FFFF;
        tick("lsu5");
        idle();
        chk("lsu5.we",   32'(wb_regwrite), 32'd1);
        chk("lsu5.rd",   32'(wb_rd),       32'd5);
        chk("lsu5.data", 32'(wb_data),     32'h7FFFF);
        chk("lsu5.busy_hold", 32'(busy_mask), 32'h0020);
        tick("lsu5_clr");
        chk("lsu5.busy_clr", 32'(busy_mask), 32'd0);
        chk("lsu5.err",      32'(err_waw),   32'd0);

        // LSU results pile up behind an ALU burst and drain in order.
        iss_valid = 1; iss_rd = 4'd4;
        tick("iss4");
        iss_rd = 4'd6;
        tick("iss6");
        idle();
        alu_valid = 1; alu_rd = 4'd1; alu_data = 19'h100;
        lsu_valid = 1; lsu_rd = 4'd4; lsu_data = 19'h0000A;
        tick("burst0");
        alu_data = 19'h101;
        lsu_rd = 4'd6; lsu_data = 19'h0000B;
        tick("burst1");
        chk("burst.full", 32'(lsu_ready), 32'd0);
        lsu_valid = 0;
        alu_data = 19'h102;
        tick("burst2");
        alu_data = 19'h103;
        tick("burst3");
        chk("burst.alu_last", 32'(wb_data), 32'h103);
        idle();
        tick("drain0");
        chk("drain0.rd",   32'(wb_rd),   32'd4);
        chk("drain0.data", 32'(wb_data), 32'h0000A);
        tick("drain1");
        chk("drain1.rd",    32'(wb_rd),     32'd6);
        chk("drain1.data",  32'(wb_data),   32'h0000B);
        chk("drain1.ready", 32'(lsu_ready), 32'd1);
        tick("drain2");
        chk("drain.err", 32'(err_waw), 32'd0);

        // rd=0 results are dropped; iss_rd=0 never marks busy.
        alu_valid = 1; alu_rd = 4'd0; alu_data = 19'h3;
        tick("x0_alu");
        chk("x0_alu.we", 32'(wb_regwrite), 32'd0);
        idle();
        iss_valid = 1; iss_rd = 4'd0;
        tick("x0_iss");
        chk("x0_iss.busy", 32'(busy_mask), 32'd0);
        idle();
        alu_valid = 1; alu_rd = 4'd0;
        lsu_valid = 1; lsu_rd = 4'd0; lsu_data = 19'h1;
        tick("x0_push");
        idle();
        tick("x0_pop");
        chk("x0_pop.we", 32'(wb_regwrite), 32'd0);
        tick("x0_empty");
        chk("x0_empty.we",    32'(wb_regwrite), 32'd0);
        chk("x0_empty.ready", 32'(lsu_ready),   32'd1);
        pulse_reset();

        // Double issue to rd=7 sets a sticky error.
        iss_valid = 1; iss_rd = 4'd7;
        tick("waw0");
        tick("waw1");
        idle();
        chk("waw.err", 32'(err_waw), 32'd1);
        for (int i = 0; i < 3; i++) tick("waw_hold");
        chk("waw.sticky", 32'(err_waw), 32'd1);
        pulse_reset();
        #1;
        chk("waw.cleared", 32'(err_waw), 32'd0);

        // Asynchronous reset with two entries queued.
        iss_valid = 1; iss_rd = 4'd8;
        tick("mid_iss8");
        iss_rd = 4'd9;
        tick("mid_iss9");
        idle();
        alu_valid = 1; alu_rd = 4'd2; alu_data = 19'h55;
        lsu_valid = 1; lsu_rd = 4'd8; lsu_data = 19'h1;
        tick("mid_push8");
        lsu_rd = 4'd9; lsu_data = 19'h2;
        tick("mid_push9");
        idle();
        #2;
        reset_n = 0;
        #1;
        chk("async.we",    32'(wb_regwrite), 32'd0);
        chk("async.rd",    32'(wb_rd),       32'd0);
        chk("async.data",  32'(wb_data),     32'd0);
        chk("async.busy",  32'(busy_mask),   32'd0);
        chk("async.err",   32'(err_waw),     32'd0);
        chk("async.ready", 32'(lsu_ready),   32'd1);
        model_reset();
        #3;
        reset_n = 1;
        for (int i = 0; i < 4; i++) begin
            tick("post_reset");
            chk("post_reset.we", 32'(wb_regwrite), 32'd0);
        end

        // Random traffic; LSU destinations mostly drawn from in-flight registers.
        pulse_reset();
        for (int c = 0; c < 400; c++) begin
            int nb_cnt;
            logic [3:0] pick[$];
            alu_valid = ($urandom_range(0, 9) < 4);
            alu_rd    = 4'($urandom_range(0, 15));
            alu_data  = 19'($urandom);
            iss_valid = ($urandom_range(0, 9) < 3);
            iss_rd    = 4'($urandom_range(0, 15));
            lsu_valid = ($urandom_range(0, 9) < 5);
            lsu_data  = 19'($urandom);
            pick.delete();
            for (int r = 1; r < 16; r++) if (m_busy[r]) pick.push_back(4'(r));
            nb_cnt = pick.size();
            if (nb_cnt > 0 && $urandom_range(0, 9) < 8)
                lsu_rd = pick[$urandom_range(0, nb_cnt - 1)];
            else
                lsu_rd = 4'($urandom_range(0, 15));
            tick("rand");
        end
        idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb_ctrl.md
# regfile_wb_ctrl

Write-side controller for the CPU's 16×19-bit register file, which has one write port and x0 hardwired to zero. It merges single-cycle ALU results and long-latency load/multiply (LSU) results onto the single write port (`wb_rd`, `wb_data`, `wb_regwrite`). Long results that lose arbitration are held in a small skid FIFO. A pending-destination scoreboard lets the issue stage stall on registers that are still in flight.

## Interface
Parameters:
- `DATA_W`, 19, register data width
- `ADDR_W`, 4, register index width (16 registers)
- `FIFO_DEPTH`, 2, long-result buffer entries (power of two, ≥2)

Ports:
- `clk`  in  1  system clock; all state on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `alu_valid`  in  1  ALU result present this cycle; no backpressure
- `alu_rd`  in  ADDR_W  ALU destination
- `alu_data`  in  DATA_W  ALU result
- `lsu_valid`  in  1  long-latency result offered
- `lsu_ready`  out  1  controller can accept the LSU result (= FIFO not full)
- `lsu_rd`  in  ADDR_W  LSU destination
- `lsu_data`  in  DATA_W  LSU result
- `iss_valid`  in  1  long-latency op issued this cycle
- `iss_rd`  in  ADDR_W  destination of the issued op
- `busy_mask`  out  16  bit i set = register i has a long result pending
- `wb_regwrite`  out  1  register-file write enable (registered)
- `wb_rd`  out  ADDR_W  register-file write index (registered)
- `wb_data`  out  DATA_W  register-file write data (registered)
- `err_waw`  out  1  sticky write-after-write violation flag

## Operation
- LSU accept: `lsu_valid && lsu_ready`. `lsu_ready` is combinational `!full` and is 1 out of reset.
- Per-cycle write source, in priority order:
  1. `alu_valid` selects the ALU result.
  2. Otherwise, a non-empty FIFO selects the FIFO head, which is popped.
  3. Otherwise, an LSU result accepted this cycle bypasses the FIFO directly.
  4. Otherwise, no write.
- An accepted LSU result that is not selected is pushed. Push and pop in the same cycle are allowed when the FIFO is full-1 or not full; the count is unchanged.
- Results are written in FIFO order, so LSU results are never reordered among themselves.
- Selected result with rd=0: `wb_regwrite` stays 0 and the result is dropped. A FIFO entry with rd=0 is still popped.
- Scoreboard:
  - `iss_valid` with `iss_rd`≠0 sets `busy_mask[iss_rd]`.
  - A long-path write to rd clears the bit at the clock edge that ends the `wb_regwrite` cycle, i.e. when the register file commits.
  - Set and clear of the same bit at the same edge: set wins.
  - `busy_mask[0]` is always 0.
- `err_waw` sets, and stays set until reset, on any of:
  - `iss_valid` to an rd that is already busy;
  - `alu_valid` to an rd (≠0) that is busy;
  - an LSU accept whose rd is not busy.
- Reset, async with `reset_n`=0: `wb_regwrite`=0, `wb_rd`=0, `wb_data`=0, FIFO empty, `busy_mask`=0, `err_waw`=0. In-flight FIFO contents are discarded.

## Timing
- Selection happens in cycle N; `wb_*` are valid in cycle N+1; the register file commits at the end of N+1.
- A busy bit set by an issue in cycle N is visible in cycle N+1.
- A busy bit clears in cycle N+2 after its result is selected in cycle N. A reader that sees busy=0 therefore gets committed data from the combinational read port.
- Worst-case FIFO residency is unbounded under continuous `alu_valid`. `lsu_ready` falls in the cycle the FIFO becomes full.
- There are no combinational paths from `lsu_valid` to `lsu_ready`.

## Structure
- Shared package `cpu19_pkg`: `DATA_W`, `REG_ADDR_W`, `NUM_REGS`, and a `wb_req_t` struct (`rd`, `data`).
- One sub-module, `wb_fifo`: parameterized synchronous FIFO with `push`, `pop`, `full`, `empty`, and head data, using wrap-around pointers plus an extra wrap bit.
- Arbitration, scoreboard and error logic live in the top module.

## Test plan
- Reset, then ALU (rd=3, 0x12345) in cycle 1 → cycle 2 shows `wb_regwrite`=1, `wb_rd`=3, `wb_data`=0x12345; `busy_mask`=0.
- Issue rd=5, then LSU (rd=5, 0x7FFFF) with the ALU idle → written one cycle later; bit 5 is set from the issue+1 cycle and clears two cycles after the LSU accept; `err_waw`=0.
- Issue rd=4 and rd=6. LSU results 4 (0xA) and 6 (0xB) arrive on consecutive cycles while `alu_valid` is held high for 4 cycles → the FIFO fills, `lsu_ready`=0, and both results are written in order (4 then 6) immediately after the ALU burst.
- ALU rd=0 and a long result with rd=0 → `wb_regwrite` never asserts and the FIFO drains; `iss_rd`=0 leaves `busy_mask`=0.
- Issue rd=7 twice before writeback → `err_waw`=1 and remains 1 until `reset_n` is pulsed.
- Assert `reset_n`=0 mid-burst with 2 FIFO entries → all outputs are zero immediately (async), with no writes after release.
